// File: rtl/proc_trace_pkg.sv
// Shared types and constants for the processor trace unit.
// Optional feature macro: TRACE_ALU_CAPTURE_EN (appends the ALU result to each entry).
package proc_trace_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } trace_state_t;

    localparam logic [15:0] HALT_IR_DEFAULT = 16'h5000;

    localparam int unsigned DEF_IR_W  = 16;
    localparam int unsigned DEF_PC_W  = 8;
    localparam int unsigned DEF_ST_W  = 4;
    localparam int unsigned DEF_CNT_W = 16;

`ifdef TRACE_ALU_CAPTURE_EN
    localparam int unsigned DEF_ALU_W = DEF_IR_W;
`else
    localparam int unsigned DEF_ALU_W = 0;
`endif

    // Bit offsets of each field inside an entry built with the default widths
    localparam int unsigned ST_LSB    = DEF_ALU_W;
    localparam int unsigned IR_LSB    = ST_LSB + DEF_ST_W;
    localparam int unsigned PC_LSB    = IR_LSB + DEF_IR_W;
    localparam int unsigned STAMP_LSB = PC_LSB + DEF_PC_W;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] stamp;
        logic [DEF_PC_W-1:0]  pc;
        logic [DEF_IR_W-1:0]  ir;
        logic [DEF_ST_W-1:0]  state;
`ifdef TRACE_ALU_CAPTURE_EN
        logic [DEF_IR_W-1:0]  alu;
`endif
    } trace_entry_t;

    // Entry width for an arbitrary field sizing
    function automatic int unsigned entry_width(input int unsigned cnt_w,
                                                input int unsigned pc_w,
                                                input int unsigned ir_w,
                                                input int unsigned st_w);
`ifdef TRACE_ALU_CAPTURE_EN
        return cnt_w + pc_w + ir_w + st_w + ir_w;
`else
        return cnt_w + pc_w + ir_w + st_w;
`endif
    endfunction

endpackage

// File: rtl/proc_trace_buffer_trace_ring.sv
// Circular entry store with show-ahead read port.
// Ports: Clk, Reset (sync, active-high), Clear, Wr_En/Wr_Data (append),
//        Rd_Ready/Rd_Valid/Rd_Data (head entry, pop on handshake),
//        Count (entries held), Ovf_c (combinational: this write loses an entry).
module trace_ring #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 44,
    parameter bit          WRAP  = 1'b1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Clear,
    input  logic                     Wr_En,
    input  logic [WIDTH-1:0]         Wr_Data,
    input  logic                     Rd_Ready,
    output logic                     Rd_Valid,
    output logic [WIDTH-1:0]         Rd_Data,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Ovf_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             pop;
    logic             push;

    assign Rd_Valid = (Count != '0);
    assign Rd_Data  = mem[rd_ptr];
    assign full     = (Count == CNT_W'(DEPTH));
    assign pop      = Rd_Valid && Rd_Ready;

    // A write into a full ring with no pop either overwrites the oldest or is dropped
    always_comb begin
        push  = Wr_En;
        Ovf_c = 1'b0;
        if (Wr_En && full && !pop) begin
            Ovf_c = 1'b1;
            push  = WRAP;
        end
        if (Clear) begin
            push  = 1'b0;
            Ovf_c = 1'b0;
        end
    end

    // Pointers and occupancy; an overwrite advances the read pointer with the write
    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop || (push && full)) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop && !full) begin
                Count <= Count + CNT_W'(1);
            end else if (pop && !push) begin
                Count <= Count - CNT_W'(1);
            end
        end
    end

    // Entry storage, contents are not reset
    always_ff @(posedge Clk) begin
        if (push && !Reset) begin
            mem[wr_ptr] <= Wr_Data;
        end
    end

endmodule

// File: rtl/proc_trace_buffer.sv
// On-chip trace unit: records one timestamped {stamp, PC, IR, State} entry per
// instruction fetch, flags halt and watchdog timeout, drains over ready/valid.
// Optional feature macro: TRACE_ALU_CAPTURE_EN adds ALU_Out_In to each entry.
// Ports: Clk, Reset (sync, active-high), Capture_En, Clear, PC_In/IR_In/State_In
//        (processor debug taps), Rd_Ready/Rd_Valid/Rd_Data (read port),
//        Count, sticky Halted/Timeout/Overflow, Busy (tracing active).
module proc_trace_buffer
    import proc_trace_pkg::*;
#(
    parameter int unsigned     IR_W    = 16,
    parameter int unsigned     PC_W    = 8,
    parameter int unsigned     ST_W    = 4,
    parameter int unsigned     DEPTH   = 16,
    parameter int unsigned     CNT_W   = 16,
    parameter logic [IR_W-1:0] HALT_IR = IR_W'(HALT_IR_DEFAULT),
    parameter int unsigned     TIMEOUT = 1024,
    parameter bit              WRAP    = 1'b1
) (
    input  logic                                         Clk,
    input  logic                                         Reset,
    input  logic                                         Capture_En,
    input  logic                                         Clear,
    input  logic [PC_W-1:0]                              PC_In,
    input  logic [IR_W-1:0]                              IR_In,
    input  logic [ST_W-1:0]                              State_In,
`ifdef TRACE_ALU_CAPTURE_EN
    input  logic [IR_W-1:0]                              ALU_Out_In,
`endif
    input  logic                                         Rd_Ready,
    output logic                                         Rd_Valid,
    output logic [entry_width(CNT_W,PC_W,IR_W,ST_W)-1:0] Rd_Data,
    output logic [$clog2(DEPTH):0]                       Count,
    output logic                                         Halted,
    output logic                                         Timeout,
    output logic                                         Overflow,
    output logic                                         Busy
);

    localparam int unsigned ENTRY_W = entry_width(CNT_W, PC_W, IR_W, ST_W);
    localparam int unsigned WD_W    = $clog2(TIMEOUT) + 1;

    trace_state_t       state;
    trace_state_t       state_n;
    logic [CNT_W-1:0]   stamp;
    logic [WD_W-1:0]    wdog;
    logic [PC_W-1:0]    last_pc;
    logic               first_flag;
    logic               start_c;
    logic               cap_c;
    logic               halt_c;
    logic               tmo_c;
    logic               ovf_c;
    logic [ENTRY_W-1:0] wr_data;

`ifdef TRACE_ALU_CAPTURE_EN
    assign wr_data = {stamp, PC_In, IR_In, State_In, ALU_Out_In};
`else
    assign wr_data = {stamp, PC_In, IR_In, State_In};
`endif

    assign Busy = (state == RUN);

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and capture decisions; disarm beats halt, halt beats timeout
    always_comb begin
        state_n = state;
        start_c = 1'b0;
        cap_c   = 1'b0;
        halt_c  = 1'b0;
        tmo_c   = 1'b0;
        case (state)
            IDLE: begin
                if (Capture_En) begin
                    state_n = RUN;
                    start_c = 1'b1;
                end
            end
            RUN: begin
                if (!Capture_En) begin
                    state_n = IDLE;
                end else if (IR_In == HALT_IR) begin
                    cap_c   = 1'b1;
                    halt_c  = 1'b1;
                    state_n = DONE;
                end else if (first_flag || (PC_In != last_pc)) begin
                    cap_c = 1'b1;
                end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    tmo_c   = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (!Capture_En) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Timestamp, watchdog, change detector and sticky flags
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stamp      <= '0;
            wdog       <= '0;
            last_pc    <= '0;
            first_flag <= 1'b0;
            Halted     <= 1'b0;
            Timeout    <= 1'b0;
            Overflow   <= 1'b0;
        end else begin
            if (start_c) begin
                stamp      <= '0;
                wdog       <= '0;
                first_flag <= 1'b1;
            end else if (state == RUN) begin
                if (stamp != '1) begin
                    stamp <= stamp + CNT_W'(1);
                end
                if (cap_c) begin
                    wdog       <= '0;
                    last_pc    <= PC_In;
                    first_flag <= 1'b0;
                end else if (wdog != '1) begin
                    wdog <= wdog + WD_W'(1);
                end
            end
            if (Clear) begin
                Halted   <= 1'b0;
                Timeout  <= 1'b0;
                Overflow <= 1'b0;
            end else begin
                Halted   <= Halted | halt_c;
                Timeout  <= Timeout | tmo_c;
                Overflow <= Overflow | ovf_c;
            end
        end
    end

    trace_ring #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .WRAP  (WRAP)
    ) u_ring (
        .Clk      (Clk),
        .Reset    (Reset),
        .Clear    (Clear),
        .Wr_En    (cap_c),
        .Wr_Data  (wr_data),
        .Rd_Ready (Rd_Ready),
        .Rd_Valid (Rd_Valid),
        .Rd_Data  (Rd_Data),
        .Count    (Count),
        .Ovf_c    (ovf_c)
    );

endmodule

// File: tb/tb_proc_trace_buffer.sv
// Directed bench: two 4-deep instances (overwrite and drop variants) share stimulus.
module tb_proc_trace_buffer;

    localparam int unsigned EW = 16 + 8 + 16 + 4;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Capture_En = 1'b0;
    logic          Clear = 1'b0;
    logic [7:0]    PC_In = 8'h00;
    logic [15:0]   IR_In = 16'h1234;
    logic [3:0]    State_In = 4'h3;
    logic          Rd_Ready = 1'b0;

    logic          a_valid, b_valid;
    logic [EW-1:0] a_data, b_data;
    logic [2:0]    a_count, b_count;
    logic          a_halted, b_halted, a_tmo, b_tmo, a_ovf, b_ovf, a_busy, b_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    proc_trace_buffer #(.DEPTH(4), .TIMEOUT(8), .WRAP(1'b1)) dut_wrap (
        .Clk(Clk), .Reset(Reset), .Capture_En(Capture_En), .Clear(Clear),
        .PC_In(PC_In), .IR_In(IR_In), .State_In(State_In), .Rd_Ready(Rd_Ready),
        .Rd_Valid(a_valid), .Rd_Data(a_data), .Count(a_count), .Halted(a_halted),
        .Timeout(a_tmo), .Overflow(a_ovf), .Busy(a_busy)
    );

    proc_trace_buffer #(.DEPTH(4), .TIMEOUT(8), .WRAP(1'b0)) dut_drop (
        .Clk(Clk), .Reset(Reset), .Capture_En(Capture_En), .Clear(Clear),
        .PC_In(PC_In), .IR_In(IR_In), .State_In(State_In), .Rd_Ready(Rd_Ready),
        .Rd_Valid(b_valid), .Rd_Data(b_data), .Count(b_count), .Halted(b_halted),
        .Timeout(b_tmo), .Overflow(b_ovf), .Busy(b_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [7:0] pc_of(input logic [EW-1:0] d);
        return d[27:20];
    endfunction

    initial begin
        step();
        step();
        Reset = 1'b0;
        check("rst_count", 64'(a_count), 64'd0);
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_flags", 64'({a_halted, a_tmo, a_ovf}), 64'd0);

        // Three PCs held three RUN cycles each
        Capture_En = 1'b1;
        PC_In = 8'h00;
        step();
        check("arm_busy", 64'(a_busy), 64'd1);
        check("arm_count", 64'(a_count), 64'd0);
        for (int p = 0; p < 3; p++) begin
            PC_In = 8'(p);
            for (int c = 0; c < 3; c++) step();
        end
        check("seq_count", 64'(a_count), 64'd3);
        check("seq_head0", 64'(a_data), 64'({16'd0, 8'h00, 16'h1234, 4'h3}));
        Rd_Ready = 1'b1; step(); Rd_Ready = 1'b0;
        check("seq_head1", 64'(a_data), 64'({16'd3, 8'h01, 16'h1234, 4'h3}));
        Rd_Ready = 1'b1; step(); Rd_Ready = 1'b0;
        check("seq_head2", 64'(a_data), 64'({16'd6, 8'h02, 16'h1234, 4'h3}));
        Rd_Ready = 1'b1; step(); Rd_Ready = 1'b0;
        check("seq_empty", 64'(a_valid), 64'd0);

        // Halt instruction at PC 05
        PC_In = 8'h05;
        IR_In = 16'h5000;
        step();
        check("halt_flag", 64'(a_halted), 64'd1);
        check("halt_busy", 64'(a_busy), 64'd0);
        check("halt_entry", 64'(a_data), 64'({16'd12, 8'h05, 16'h5000, 4'h3}));
        IR_In = 16'h1234;
        PC_In = 8'h06; step();
        PC_In = 8'h07; step();
        check("halt_nomore", 64'(a_count), 64'd1);
        Rd_Ready = 1'b1; step(); Rd_Ready = 1'b0;
        check("halt_drained", 64'(a_count), 64'd0);

        // Watchdog: PC held after one capture
        Capture_En = 1'b0; step();
        check("done_to_idle", 64'(a_busy), 64'd0);
        Capture_En = 1'b1; step();
        step();
        check("wd_first", 64'(a_count), 64'd1);
        for (int c = 0; c < 7; c++) step();
        check("wd_not_yet", 64'(a_tmo), 64'd0);
        check("wd_busy", 64'(a_busy), 64'd1);
        step();
        check("wd_fired", 64'(a_tmo), 64'd1);
        check("wd_done", 64'(a_busy), 64'd0);
        check("wd_no_entry", 64'(a_count), 64'd1);
        Clear = 1'b1; step(); Clear = 1'b0;
        check("clr_flags", 64'({a_halted, a_tmo, a_ovf}), 64'd0);
        check("clr_count", 64'(a_count), 64'd0);

        // Six distinct PCs into four slots
        Capture_En = 1'b0; step();
        PC_In = 8'h10;
        Capture_En = 1'b1; step();
        for (int p = 0; p < 6; p++) begin
            PC_In = 8'(8'h10 + p);
            step();
        end
        check("wrap_count", 64'(a_count), 64'd4);
        check("drop_count", 64'(b_count), 64'd4);
        check("wrap_ovf", 64'(a_ovf), 64'd1);
        check("drop_ovf", 64'(b_ovf), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_drain%0d", i), 64'(pc_of(a_data)), 64'(8'h12 + i));
            check($sformatf("drop_drain%0d", i), 64'(pc_of(b_data)), 64'(8'h10 + i));
            Rd_Ready = 1'b1; step(); Rd_Ready = 1'b0;
        end
        check("wrap_empty", 64'(a_count), 64'd0);

        // Full ring with a pop on the capture edge, then Clear against pop and write
        Clear = 1'b1; step(); Clear = 1'b0;
        for (int p = 0; p < 4; p++) begin
            PC_In = 8'(8'h20 + p);
            step();
        end
        check("full_count", 64'(a_count), 64'd4);
        PC_In = 8'h24;
        Rd_Ready = 1'b1; step();
        check("fp_count", 64'(a_count), 64'd4);
        check("fp_head", 64'(pc_of(a_data)), 64'h21);
        check("fp_drop_head", 64'(pc_of(b_data)), 64'h21);
        check("fp_no_ovf", 64'({a_ovf, b_ovf}), 64'd0);
        PC_In = 8'h25;
        Clear = 1'b1; step();
        Clear = 1'b0; Rd_Ready = 1'b0;
        check("clr_wins", 64'({a_count, b_count}), 64'd0);
        check("clr_valid", 64'(a_valid), 64'd0);

        // Reset mid-RUN with three entries and Overflow set
        for (int p = 0; p < 5; p++) begin
            PC_In = 8'(8'h30 + p);
            step();
        end
        Rd_Ready = 1'b1; step(); Rd_Ready = 1'b0;
        check("pre_rst_count", 64'(a_count), 64'd3);
        check("pre_rst_ovf", 64'(a_ovf), 64'd1);
        check("pre_rst_busy", 64'(a_busy), 64'd1);
        Reset = 1'b1; step();
        check("mid_rst_count", 64'(a_count), 64'd0);
        check("mid_rst_valid", 64'(a_valid), 64'd0);
        check("mid_rst_flags", 64'({a_halted, a_tmo, a_ovf}), 64'd0);
        check("mid_rst_busy", 64'(a_busy), 64'd0);
        Reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
